// File: rtl/ps2_rx.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_rx
//  Purpose  : PS/2 device-to-host frame receiver. The raw PS/2 clock is
//             synchronised and glitch-filtered. Data is sampled on filtered
//             falling edges to build the 11-bit frame (start, 8 data bits
//             LSB first, odd parity, stop). The byte is presented with a
//             one-cycle done pulse, and parity and stop-bit errors are
//             flagged. A watchdog aborts any frame that stalls.
//  Ports    : clk_i        - system clock
//             reset_i      - asynchronous, active-high reset
//             rx_en_i      - allows a new frame to start (looked at in IDLE)
//             ps2d_i       - PS/2 data pin
//             ps2c_i       - PS/2 clock pin
//             rx_data_o    - last received byte
//             rx_done_o    - one-cycle pulse, frame complete
//             parity_err_o - last frame failed odd parity
//             frame_err_o  - last frame had a stop bit of 0
//             timeout_o    - one-cycle pulse, frame aborted by the watchdog
//             idle_o       - receiver is idle
//  Revision : 1.0 - initial release
// ============================================================================
module ps2_rx #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 200_000
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       rx_en_i,
    input  logic       ps2d_i,
    input  logic       ps2c_i,
    output logic [7:0] rx_data_o,
    output logic       rx_done_o,
    output logic       parity_err_o,
    output logic       frame_err_o,
    output logic       timeout_o,
    output logic       idle_o
);

    localparam int c_WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_STOP = 2'd2
    } state_t;

    // ---------------------------------------------------------------- sync/filter
    logic [1:0]            r_c_sync;
    logic [1:0]            r_d_sync;
    logic [FILTER_LEN-1:0] r_filt_sh;
    logic [FILTER_LEN-1:0] w_filt_sh_next;
    logic                  r_filt;
    logic                  w_filt_next;
    logic                  w_fall;
    logic                  w_d;

    generate
        if (FILTER_LEN == 1) begin : g_filt_one
            assign w_filt_sh_next = r_c_sync[1];
        end else begin : g_filt_multi
            assign w_filt_sh_next = {r_filt_sh[FILTER_LEN-2:0], r_c_sync[1]};
        end
    endgenerate

    // Hysteresis: the filtered clock only moves once every sample agrees.
    always_comb begin
        w_filt_next = r_filt;
        if (&w_filt_sh_next) begin
            w_filt_next = 1'b1;
        end else if (~|w_filt_sh_next) begin
            w_filt_next = 1'b0;
        end
    end

    // Edge is flagged in the cycle the filter settles low, not a cycle later.
    assign w_fall = r_filt & ~w_filt_next;
    assign w_d    = r_d_sync[1];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_c_sync  <= 2'b11;
            r_d_sync  <= 2'b11;
            r_filt_sh <= '1;
            r_filt    <= 1'b1;
        end else begin
            r_c_sync  <= {r_c_sync[0], ps2c_i};
            r_d_sync  <= {r_d_sync[0], ps2d_i};
            r_filt_sh <= w_filt_sh_next;
            r_filt    <= w_filt_next;
        end
    end

    // ---------------------------------------------------------------- frame FSM
    state_t              r_state, w_state_next;
    logic [8:0]          r_shift, w_shift_next;
    logic [3:0]          r_cnt, w_cnt_next;
    logic [c_WD_W-1:0]   r_wd, w_wd_next;
    logic [7:0]          r_data, w_data_next;
    logic                r_perr, w_perr_next;
    logic                r_ferr, w_ferr_next;
    logic                r_done, w_done_next;
    logic                w_expire;

    assign w_expire = (r_state != S_IDLE) && (r_wd == c_WD_LAST);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
            r_wd    <= '0;
            r_data  <= '0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_shift <= w_shift_next;
            r_cnt   <= w_cnt_next;
            r_wd    <= w_wd_next;
            r_data  <= w_data_next;
            r_perr  <= w_perr_next;
            r_ferr  <= w_ferr_next;
            r_done  <= w_done_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_shift_next = r_shift;
        w_cnt_next   = r_cnt;
        w_wd_next    = r_wd;
        w_data_next  = r_data;
        w_perr_next  = r_perr;
        w_ferr_next  = r_ferr;
        w_done_next  = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_wd_next = '0;
                if (w_fall && rx_en_i && !w_d) begin
                    w_state_next = S_DATA;
                    w_cnt_next   = 4'd9;
                end
            end
            S_DATA: begin
                // Expiry takes priority over a coincident edge.
                if (w_expire) begin
                    w_state_next = S_IDLE;
                    w_wd_next    = '0;
                end else if (w_fall) begin
                    w_shift_next = {w_d, r_shift[8:1]};
                    w_cnt_next   = r_cnt - 4'd1;
                    w_wd_next    = '0;
                    if (r_cnt == 4'd1) begin
                        w_state_next = S_STOP;
                    end
                end else begin
                    w_wd_next = r_wd + 1'b1;
                end
            end
            S_STOP: begin
                if (w_expire) begin
                    w_state_next = S_IDLE;
                    w_wd_next    = '0;
                end else if (w_fall) begin
                    w_state_next = S_IDLE;
                    w_wd_next    = '0;
                    w_done_next  = 1'b1;
                    w_data_next  = r_shift[7:0];
                    w_perr_next  = ~^r_shift;
                    w_ferr_next  = ~w_d;
                end else begin
                    w_wd_next = r_wd + 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign rx_data_o    = r_data;
    assign rx_done_o    = r_done;
    assign parity_err_o = r_perr;
    assign frame_err_o  = r_ferr;
    assign timeout_o    = w_expire;
    assign idle_o       = (r_state == S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ps2_rx
//  Purpose  : Self-checking bench for ps2_rx. Frames are driven as a PS/2
//             device would drive them; expected results are queued when a
//             frame is sent and compared when rx_done_o pulses.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_rx;

    localparam int FILTER_LEN = 8;
    localparam int TIMEOUT    = 500;
    localparam int HALF       = 30;   // clk cycles per PS/2 clock half period

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic       rx_en_i;
    logic       ps2d_i;
    logic       ps2c_i;
    logic [7:0] rx_data_o;
    logic       rx_done_o;
    logic       parity_err_o;
    logic       frame_err_o;
    logic       timeout_o;
    logic       idle_o;

    ps2_rx #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .rx_en_i      (rx_en_i),
        .ps2d_i       (ps2d_i),
        .ps2c_i       (ps2c_i),
        .rx_data_o    (rx_data_o),
        .rx_done_o    (rx_done_o),
        .parity_err_o (parity_err_o),
        .frame_err_o  (frame_err_o),
        .timeout_o    (timeout_o),
        .idle_o       (idle_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    exp_t q[$];
    int   errors    = 0;
    int   checks    = 0;
    int   done_cnt  = 0;
    int   to_cnt    = 0;
    int   to_cycle  = 0;
    int   cycle     = 0;
    int   last_fall = 0;
    logic prev_done = 1'b0;

    always @(posedge clk_i) cycle <= cycle + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // Drives the first nbits bits of {stop, parity, data, start}.
    task automatic send_frame(input logic [7:0] d, input logic p, input logic stop, input int nbits);
        logic [10:0] fr;
        fr = {stop, p, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2d_i = fr[i];
            wait_cycles(HALF);
            ps2c_i    = 1'b0;
            last_fall = cycle;
            wait_cycles(HALF);
            ps2c_i = 1'b1;
        end
        wait_cycles(HALF);
        ps2d_i = 1'b1;
        wait_cycles(3 * HALF);
    endtask

    task automatic push(input logic [7:0] d, input logic p, input logic stop);
        exp_t e;
        e.d  = d;
        e.pe = ~^{p, d};
        e.fe = ~stop;
        q.push_back(e);
    endtask

    // Scoreboard side: compare every done pulse against the queued frame.
    always @(negedge clk_i) begin
        if (rx_done_o === 1'b1) begin
            exp_t e;
            done_cnt++;
            check("done_single_cycle", {31'd0, prev_done}, 32'd0);
            if (q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                check("rx_data", {24'd0, rx_data_o}, {24'd0, e.d});
                check("parity_err", {31'd0, parity_err_o}, {31'd0, e.pe});
                check("frame_err", {31'd0, frame_err_o}, {31'd0, e.fe});
            end
        end
        if (timeout_o === 1'b1) begin
            to_cnt++;
            to_cycle = cycle;
        end
        prev_done = rx_done_o;
    end

    initial begin
        int exp_done;
        int lat;
        reset_i = 1'b1;
        rx_en_i = 1'b1;
        ps2d_i  = 1'b1;
        ps2c_i  = 1'b1;
        exp_done = 0;
        wait_cycles(5);
        check("reset_rx_data", {24'd0, rx_data_o}, 32'd0);
        check("reset_done", {31'd0, rx_done_o}, 32'd0);
        check("reset_perr", {31'd0, parity_err_o}, 32'd0);
        check("reset_ferr", {31'd0, frame_err_o}, 32'd0);
        check("reset_timeout", {31'd0, timeout_o}, 32'd0);
        check("reset_idle", {31'd0, idle_o}, 32'd1);
        reset_i = 1'b0;
        wait_cycles(20);
        check("no_edge_after_reset", {31'd0, idle_o}, 32'd1);

        // Clean frame 0xFA.
        push(8'hFA, 1'b1, 1'b1);
        send_frame(8'hFA, 1'b1, 1'b1, 11);
        exp_done++;
        check("done_fa", done_cnt, exp_done);
        check("idle_after_fa", {31'd0, idle_o}, 32'd1);

        // Bad parity then good parity.
        push(8'hAA, 1'b0, 1'b1);
        send_frame(8'hAA, 1'b0, 1'b1, 11);
        exp_done++;
        check("perr_held", {31'd0, parity_err_o}, 32'd1);
        push(8'h55, 1'b1, 1'b1);
        send_frame(8'h55, 1'b1, 1'b1, 11);
        exp_done++;
        check("perr_cleared", {31'd0, parity_err_o}, 32'd0);

        // Stop bit 0.
        push(8'h3C, 1'b1, 1'b0);
        send_frame(8'h3C, 1'b1, 1'b0, 11);
        exp_done++;
        check("done_3c", done_cnt, exp_done);

        // Clock stops after start + 4 data bits.
        send_frame(8'h55, 1'b1, 1'b1, 5);
        for (int i = 0; i < TIMEOUT + 200 && to_cnt == 0; i++) wait_cycles(1);
        check("timeout_seen", to_cnt, 32'd1);
        lat = to_cycle - last_fall;
        check("timeout_latency", {31'd0, (lat >= TIMEOUT + FILTER_LEN) && (lat <= TIMEOUT + FILTER_LEN + 2)}, 32'd1);
        wait_cycles(2);
        check("timeout_idle", {31'd0, idle_o}, 32'd1);
        check("timeout_no_done", done_cnt, exp_done);
        check("timeout_data_kept", {24'd0, rx_data_o}, 32'h3C);
        check("timeout_ferr_kept", {31'd0, frame_err_o}, 32'd1);
        push(8'h55, 1'b1, 1'b1);
        send_frame(8'h55, 1'b1, 1'b1, 11);
        exp_done++;
        check("done_after_timeout", done_cnt, exp_done);

        // Short glitch on the clock while idle.
        ps2c_i = 1'b0;
        wait_cycles(3);
        ps2c_i = 1'b1;
        wait_cycles(40);
        check("glitch_idle", {31'd0, idle_o}, 32'd1);
        check("glitch_no_done", done_cnt, exp_done);

        // Receiver disabled: frame ignored, then accepted when enabled.
        rx_en_i = 1'b0;
        send_frame(8'h12, 1'b1, 1'b1, 11);
        check("disabled_no_done", done_cnt, exp_done);
        check("disabled_idle", {31'd0, idle_o}, 32'd1);
        rx_en_i = 1'b1;
        push(8'h12, 1'b1, 1'b1);
        send_frame(8'h12, 1'b1, 1'b1, 11);
        exp_done++;
        check("done_12", done_cnt, exp_done);

        // Reset in the middle of a frame.
        send_frame(8'h99, 1'b1, 1'b1, 5);
        check("mid_frame_busy", {31'd0, idle_o}, 32'd0);
        reset_i = 1'b1;
        wait_cycles(3);
        check("midreset_rx_data", {24'd0, rx_data_o}, 32'd0);
        check("midreset_idle", {31'd0, idle_o}, 32'd1);
        check("midreset_ferr", {31'd0, frame_err_o}, 32'd0);
        reset_i = 1'b0;
        wait_cycles(20);
        check("midreset_no_done", done_cnt, exp_done);
        push(8'h99, 1'b1, 1'b1);
        send_frame(8'h99, 1'b1, 1'b1, 11);
        exp_done++;
        check("done_99", done_cnt, exp_done);

        wait_cycles(20);
        check("queue_empty", q.size(), 32'd0);
        check("timeout_total", to_cnt, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
